spi_cs_arbiter: RTL and testbench

SPI_CS_ARBITER -- requirements
Module: spi_cs_arbiter

---
 rtl/spi_cs_arbiter.sv | 159 +++++++++++++++
 tb/tb_spi_cs_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_cs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : spi_cs_arbiter
// Description : Round-robin arbiter handing one SPI host to NReq requesters,
//               with a one-cycle CS setup, enforced CS gap and owner timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_cs_arbiter #(
  parameter int NReq          = 4,
  parameter int GapCycles     = 2,
  parameter int TimeoutCycles = 1023
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NReq-1:0] req_i,
  input  logic [NReq-1:0] done_i,
  output logic [NReq-1:0] gnt_o,
  output logic [NReq-1:0] cs_no,
  output logic            busy_o,
  output logic [2:0]      owner_o,
  output logic            timeout_o
);

  localparam int c_tmo_w = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam int c_gap_w = (GapCycles > 1) ? $clog2(GapCycles) : 1;
  localparam logic [c_tmo_w-1:0] c_tmo_last =
    c_tmo_w'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
  localparam logic [c_gap_w-1:0] c_gap_last =
    c_gap_w'((GapCycles > 0) ? GapCycles - 1 : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OWN   = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam state_t c_rel_state = (GapCycles == 0) ? IDLE : GAP;
  localparam logic   c_rel_busy  = (GapCycles != 0);

  state_t              r_state;
  logic [2:0]          r_owner;
  logic [c_tmo_w-1:0]  r_tcnt;
  logic [c_gap_w-1:0]  r_gcnt;
  logic [NReq-1:0]     r_gnt;
  logic [NReq-1:0]     r_cs_n;
  logic                r_busy;
  logic                r_timeout;

  logic [NReq-1:0]     w_own_oh;
  logic                w_own_req;
  logic                w_own_done;
  logic                w_tmo_hit;
  logic                w_release;
  logic [2:0]          w_win;
  logic [NReq-1:0]     w_win_oh;
  int                  w_best;

  always_comb begin
    w_own_oh = '0;
    for (int i = 0; i < NReq; i++) begin
      w_own_oh[i] = (r_owner == 3'(i));
    end
  end

  assign w_own_req  = |(req_i & w_own_oh);
  assign w_own_done = |(done_i & w_own_oh);
  // The counter reaching TimeoutCycles-1 here means this edge closes the
  // TimeoutCycles-th owned cycle.
  assign w_tmo_hit  = (TimeoutCycles != 0) && (r_tcnt == c_tmo_last);
  assign w_release  = w_own_done || !w_own_req || w_tmo_hit;

  // Winner is the requester at the smallest upward distance from owner+1.
  always_comb begin
    w_win    = r_owner;
    w_win_oh = '0;
    w_best   = NReq;
    for (int i = 0; i < NReq; i++) begin
      if (req_i[i] && (((i + NReq - 1 - int'(r_owner)) % NReq) < w_best)) begin
        w_best      = (i + NReq - 1 - int'(r_owner)) % NReq;
        w_win       = 3'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_owner   <= 3'(NReq - 1);
      r_tcnt    <= '0;
      r_gcnt    <= '0;
      r_gnt     <= '0;
      r_cs_n    <= '1;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|req_i) begin
            r_state <= SETUP;
            r_owner <= w_win;
            r_cs_n  <= ~w_win_oh;
            r_busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (!w_own_req) begin
            r_state <= c_rel_state;
            r_cs_n  <= '1;
            r_busy  <= c_rel_busy;
            r_gcnt  <= '0;
          end else begin
            r_state <= OWN;
            r_gnt   <= w_own_oh;
            r_tcnt  <= '0;
          end
        end
        OWN: begin
          if (w_release) begin
            r_state   <= c_rel_state;
            r_gnt     <= '0;
            r_cs_n    <= '1;
            r_busy    <= c_rel_busy;
            r_gcnt    <= '0;
            // Only a release caused purely by the counter is reported.
            r_timeout <= w_tmo_hit && !w_own_done && w_own_req;
          end else if (TimeoutCycles != 0) begin
            r_tcnt <= r_tcnt + 1'b1;
          end
        end
        GAP: begin
          if (r_gcnt == c_gap_last) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_gcnt <= r_gcnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= '0;
          r_cs_n  <= '1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o     = r_gnt;
  assign cs_no     = r_cs_n;
  assign busy_o    = r_busy;
  assign owner_o   = r_owner;
  assign timeout_o = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_spi_cs_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_cs_arbiter
// Description : Self-checking bench for spi_cs_arbiter (gap=2/timeout=4 and
//               gap=0/no-timeout instances driven by shared stimulus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_cs_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] done;

  logic [N-1:0] gnt_a, cs_a, gnt_b, cs_b;
  logic         busy_a, tmo_a, busy_b, tmo_b;
  logic [2:0]   owner_a, owner_b;
  logic [12:0]  out_a, out_b;

  assign out_a = {gnt_a, cs_a, busy_a, owner_a, tmo_a};
  assign out_b = {gnt_b, cs_b, busy_b, owner_b, tmo_b};

  always #5 clk = ~clk;

  spi_cs_arbiter #(.NReq(N), .GapCycles(2), .TimeoutCycles(4)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .gnt_o(gnt_a), .cs_no(cs_a), .busy_o(busy_a), .owner_o(owner_a),
    .timeout_o(tmo_a)
  );

  spi_cs_arbiter #(.NReq(N), .GapCycles(0), .TimeoutCycles(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .req_i(req), .done_i(done),
    .gnt_o(gnt_b), .cs_no(cs_b), .busy_o(busy_b), .owner_o(owner_b),
    .timeout_o(tmo_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 setup, 2 owned, 3 gap.
  int p_gap[2] = '{2, 0};
  int p_tmo[2] = '{4, 0};
  int m_ph[2]  = '{0, 0};
  int m_own[2] = '{N - 1, N - 1};
  int m_age[2] = '{0, 0};
  int m_gl[2]  = '{0, 0};
  bit m_tmo[2] = '{1'b0, 1'b0};

  typedef struct {
    bit           rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [12:0]  exp;
  } vec_t;

  vec_t vq[$];

  task automatic model_step(int k, bit r, logic [N-1:0] rq, logic [N-1:0] dn);
    bit rel;
    bit forced;
    int w;
    m_tmo[k] = 1'b0;
    if (r) begin
      m_ph[k] = 0; m_own[k] = N - 1; m_age[k] = 0; m_gl[k] = 0;
      return;
    end
    rel = 1'b0;
    forced = 1'b0;
    case (m_ph[k])
      0: if (rq != 0) begin
        w = -1;
        for (int d = 1; d <= N; d++)
          if (w < 0 && rq[(m_own[k] + d) % N]) w = (m_own[k] + d) % N;
        m_own[k] = w;
        m_ph[k] = 1;
      end
      1: if (!rq[m_own[k]]) rel = 1'b1;
         else begin m_ph[k] = 2; m_age[k] = 0; end
      2: begin
        m_age[k]++;
        forced = (p_tmo[k] != 0) && (m_age[k] == p_tmo[k]);
        if (dn[m_own[k]] || !rq[m_own[k]] || forced) begin
          rel = 1'b1;
          m_tmo[k] = forced && !dn[m_own[k]] && rq[m_own[k]];
        end
      end
      default: begin
        m_gl[k]--;
        if (m_gl[k] == 0) m_ph[k] = 0;
      end
    endcase
    if (rel) begin
      if (p_gap[k] == 0) m_ph[k] = 0;
      else begin m_ph[k] = 3; m_gl[k] = p_gap[k]; end
    end
  endtask

  function automatic logic [12:0] exp_vec(int k);
    logic [N-1:0] g;
    logic [N-1:0] c;
    g = '0;
    c = '1;
    if (m_ph[k] == 2) g[m_own[k]] = 1'b1;
    if (m_ph[k] == 1 || m_ph[k] == 2) c[m_own[k]] = 1'b0;
    return {g, c, (m_ph[k] != 0), 3'(m_own[k]), m_tmo[k]};
  endfunction

  function automatic bit inv_ok(logic [N-1:0] g, logic [N-1:0] c);
    return ($countones(~c) <= 1) && $onehot0(g) && ((g & c) == '0);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, advance the model on the rising edge,
  // then compare both DUTs at the next falling edge.
  task automatic step(bit r, logic [N-1:0] rq, logic [N-1:0] dn);
    rst = r; req = rq; done = dn;
    @(posedge clk);
    model_step(0, r, rq, dn);
    model_step(1, r, rq, dn);
    @(negedge clk);
    check("model_a", 32'(out_a), 32'(exp_vec(0)));
    check("model_b", 32'(out_b), 32'(exp_vec(1)));
    check("inv_a", 32'(inv_ok(gnt_a, cs_a)), 32'd1);
    check("inv_b", 32'(inv_ok(gnt_b, cs_b)), 32'd1);
  endtask

  task automatic add(bit r, logic [N-1:0] rq, logic [N-1:0] dn, logic [N-1:0] g,
                     logic [N-1:0] c, logic b, logic [2:0] o, logic t);
    vec_t v;
    v.rst = r; v.req = rq; v.done = dn; v.exp = {g, c, b, o, t};
    vq.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] rq;
    logic [N-1:0] dn;
    int waited;

    rst = 1'b1; req = '0; done = '0;
    @(negedge clk);

    // Single request with done at the timeout edge, then a pure timeout and
    // a request withdrawn during setup (expectations for the gap=2 instance).
    add(1, 4'h0, 4'h0, 4'h0, 4'hF, 0, 3'd3, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 3'd3, 0);
    add(0, 4'h1, 4'h0, 4'h0, 4'hE, 1, 3'd0, 0);
    for (int i = 0; i < 4; i++) add(0, 4'h1, 4'h0, 4'h1, 4'hE, 1, 3'd0, 0);
    add(0, 4'h1, 4'h1, 4'h0, 4'hF, 1, 3'd0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 1, 3'd0, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 3'd0, 0);
    add(0, 4'h4, 4'h0, 4'h0, 4'hB, 1, 3'd2, 0);
    for (int i = 0; i < 4; i++) add(0, 4'h4, 4'h0, 4'h4, 4'hB, 1, 3'd2, 0);
    add(0, 4'h4, 4'h0, 4'h0, 4'hF, 1, 3'd2, 1);
    add(0, 4'h4, 4'h0, 4'h0, 4'hF, 1, 3'd2, 0);
    add(0, 4'h4, 4'h0, 4'h0, 4'hF, 0, 3'd2, 0);
    add(0, 4'h4, 4'h0, 4'h0, 4'hB, 1, 3'd2, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 1, 3'd2, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 1, 3'd2, 0);
    add(0, 4'h0, 4'h0, 4'h0, 4'hF, 0, 3'd2, 0);
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].req, vq[i].done);
      check($sformatf("vec%0d", i), 32'(out_a), 32'(vq[i].exp));
    end

    // Round-robin with all requests held; each owner done after 3 owned cycles.
    step(1, '0, '0);
    for (int k = 0; k < 5; k++) begin
      waited = 0;
      while (gnt_a == '0 && waited < 20) begin
        step(0, 4'hF, '0);
        waited++;
      end
      if (gnt_a == '0) begin
        total++; bad++;
        $display("FAIL rr_wait%0d: got no grant expected grant within 20 cycles", k);
      end else begin
        check($sformatf("rr_gnt%0d", k), 32'(gnt_a), 32'(4'b0001 << (k % 4)));
        check($sformatf("rr_owner%0d", k), 32'(owner_a), 32'(k % 4));
        step(0, 4'hF, '0);
        step(0, 4'hF, '0);
        step(0, 4'hF, gnt_a);
      end
    end

    // Zero-gap handover on the second instance.
    step(1, '0, '0);
    step(0, 4'b0011, '0);
    check("gap0_setup_cs", 32'(cs_b), 32'(4'b1110));
    step(0, 4'b0011, '0);
    check("gap0_own_gnt", 32'(gnt_b), 32'(4'b0001));
    step(0, 4'b0011, 4'b0001);
    check("gap0_rel_cs", 32'(cs_b), 32'(4'b1111));
    step(0, 4'b0011, '0);
    check("gap0_next_cs", 32'(cs_b), 32'(4'b1101));
    check("gap0_next_owner", 32'(owner_b), 32'd1);

    // Reset while requester 3 owns the bus, overriding a same-cycle done.
    step(1, '0, '0);
    step(0, 4'b1000, '0);
    step(0, 4'b1000, '0);
    check("mid3_gnt", 32'(gnt_a), 32'(4'b1000));
    step(1, 4'b1000, 4'b1000);
    check("rst3_out", 32'(out_a), 32'({4'h0, 4'hF, 1'b0, 3'd3, 1'b0}));
    step(0, 4'b1001, '0);
    check("rst3_next_owner", 32'(owner_a), 32'd0);
    check("rst3_next_cs", 32'(cs_a), 32'(4'b1110));

    // Reset while requester 1 owns: the pointer returns to NReq-1.
    step(1, '0, '0);
    step(0, 4'b0010, '0);
    step(0, 4'b0010, '0);
    check("mid1_gnt", 32'(gnt_a), 32'(4'b0010));
    step(1, 4'b0010, '0);
    check("rst1_owner", 32'(owner_a), 32'd3);
    step(0, 4'b1010, '0);
    check("rst1_next_owner", 32'(owner_a), 32'd1);
    check("rst1_next_cs", 32'(cs_a), 32'(4'b1101));

    // Randomized traffic against the model.
    rq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 7) == 0) rq[i] = ~rq[i];
      dn = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step($urandom_range(0, 199) == 0, rq, dn);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
